// File: rtl/store_write_buffer.sv
// Posted-store FIFO between the core data port and the SRAM write port, with byte-lane load forwarding.
// Define STORE_BUFFER_COALESCE_EN to merge a store into the newest entry when the word address matches.
module store_write_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [XLEN-1:0] core_address_i,
  input  logic            core_write_enable_i,
  input  logic [XLEN-1:0] core_write_data_i,
  input  logic [3:0]      core_write_strobe_i,
  output logic [XLEN-1:0] core_read_data_o,
  output logic [XLEN-1:0] mem_read_address_o,
  input  logic [XLEN-1:0] mem_read_data_i,
  output logic            mem_write_valid_o,
  input  logic            mem_write_ready_i,
  output logic [XLEN-1:0] mem_write_address_o,
  output logic [XLEN-1:0] mem_write_data_o,
  output logic [3:0]      mem_write_strobe_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = XLEN - 2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [WW-1:0]   r_addr [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [3:0]      r_strb [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [AW:0]     r_count;
  logic            r_overflow;

  logic [WW-1:0]   w_core_word;
  logic [AW-1:0]   w_newest;
  logic [AW-1:0]   w_scan;
  logic [XLEN-1:0] w_fwd;
  logic            w_head_vld;
  logic            w_req;
  logic            w_pop;
  logic            w_full;
  logic            w_merge;
  logic            w_push;
  logic            w_drop;

  assign w_core_word = core_address_i[XLEN-1:2];
  assign w_newest    = r_tail - AW'(1);
  assign w_head_vld  = r_valid[r_head];
  assign w_full      = (r_count == FULL_CNT);
  assign w_req       = core_write_enable_i && (core_write_strobe_i != 4'b0000);
  assign w_pop       = w_head_vld && mem_write_ready_i;

`ifdef STORE_BUFFER_COALESCE_EN
  // The head is already presented to the SRAM, so it must never change under a merge.
  assign w_merge = w_req && r_valid[w_newest] && (r_addr[w_newest] == w_core_word) &&
                   (w_newest != r_head);
`else
  assign w_merge = 1'b0;
`endif

  assign w_push = w_req && !w_merge && (!w_full || w_pop);
  assign w_drop = w_req && !w_merge && w_full && !w_pop;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_valid    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + AW'(1);
      end
      // Set after clear: when full, a same-cycle push reuses the slot being popped.
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr[r_tail] <= w_core_word;
      r_data[r_tail] <= core_write_data_i;
      r_strb[r_tail] <= core_write_strobe_i;
    end
    if (w_merge) begin
      r_strb[w_newest] <= r_strb[w_newest] | core_write_strobe_i;
      for (int b = 0; b < 4; b++) begin
        if (core_write_strobe_i[b]) begin
          r_data[w_newest][8*b +: 8] <= core_write_data_i[8*b +: 8];
        end
      end
    end
  end

  // Walk oldest to newest so later matching bytes overwrite earlier ones.
  always_comb begin
    w_fwd  = mem_read_data_i;
    w_scan = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_scan = r_head + AW'(i);
      if (r_valid[w_scan] && (r_addr[w_scan] == w_core_word)) begin
        for (int b = 0; b < 4; b++) begin
          if (r_strb[w_scan][b]) begin
            w_fwd[8*b +: 8] = r_data[w_scan][8*b +: 8];
          end
        end
      end
    end
  end

  assign core_read_data_o    = w_fwd;
  assign mem_read_address_o  = core_address_i;
  assign mem_write_valid_o   = w_head_vld;
  assign mem_write_address_o = w_head_vld ? {r_addr[r_head], 2'b00} : '0;
  assign mem_write_data_o    = w_head_vld ? r_data[r_head] : '0;
  assign mem_write_strobe_o  = w_head_vld ? r_strb[r_head] : 4'b0000;
  assign full_o              = w_full;
  assign empty_o             = (r_count == '0);
  assign overflow_o          = r_overflow;

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Sits directly downstream of the single-cycle core's data-memory port (address, write enable, write data, write strobe, read data).
- Accepts core stores in one cycle and drains them to the data SRAM write port through a valid/ready handshake, so a slow or busy write port never costs the core a cycle.
- Core loads return SRAM read data combinationally. Pending buffered bytes are forwarded over that data, so loads always see the newest store.

Parameters:
- XLEN, 32, data and address width.
- DEPTH, 4, number of buffer entries; must be a power of 2 and at least 2.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  asynchronous, active-high reset
- core_address_i  input  XLEN  byte address from the core ALU
- core_write_enable_i  input  1  store request this cycle
- core_write_data_i  input  XLEN  lane-aligned store data
- core_write_strobe_i  input  4  byte-lane enables
- core_read_data_o  output  XLEN  load data, with forwarding applied
- mem_read_address_o  output  XLEN  equals core_address_i; drives the SRAM's combinational read port
- mem_read_data_i  input  XLEN  SRAM read data
- mem_write_valid_o  output  1  head entry is presented
- mem_write_ready_i  input  1  SRAM accepts the write
- mem_write_address_o  output  XLEN  head word address, with bits [1:0] = 0
- mem_write_data_o  output  XLEN  head data
- mem_write_strobe_o  output  4  head strobe
- full_o  output  1  count == DEPTH
- empty_o  output  1  count == 0
- overflow_o  output  1  sticky: a store was dropped

Behaviour:
- Storage is a circular FIFO.
  - Each entry holds a word address (bits [31:2]), data, strobe and a valid bit.
  - Head/tail pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits wide.
- Reset (asynchronous, any time, including mid-drain):
  - Pointers, count and all valid bits go to 0; overflow_o goes to 0.
  - Pending entries are discarded, not drained.
  - Output values during reset: mem_write_valid_o=0, empty_o=1, full_o=0, mem_write_* = 0.
- Push condition: core_write_enable_i=1 and core_write_strobe_i!=0 and (count<DEPTH or a pop happens in the same cycle).
  - The entry is written at the rising edge.
- Zero-strobe writes are ignored: no push, no overflow.
- Pop condition: mem_write_valid_o && mem_write_ready_i. The head advances at the edge.
- Simultaneous push and pop: count is unchanged. This is legal even when full.
  - With count=1, the pushed entry becomes head on the next cycle.
- Push attempted while full with no pop:
  - The store is dropped and overflow_o sets on the next edge.
  - overflow_o stays 1 until reset.
- Latency: a store accepted at edge N drives mem_write_valid_o=1 from cycle N+1 if the buffer was empty.
  - Minimum store-to-SRAM latency is one cycle.
  - Throughput is one pop per cycle while ready=1.
- Handshake rule: once mem_write_valid_o=1, the valid, address, data and strobe outputs stay stable until the pop.
  - Valid never depends combinationally on ready.
- mem_write_* outputs are driven from registered storage only, with no combinational path from core inputs.
- Forwarding (combinational, per byte lane b = 0..3):
  - Scan valid entries from oldest to newest.
  - An entry matches lane b if its word address equals core_address_i[31:2] and its strobe[b]=1.
  - The newest matching byte wins. With no match, the byte comes from mem_read_data_i.
  - The entry being popped this cycle still forwards.
  - The store being pushed this cycle is not forwarded; the core never loads and stores in the same cycle.
- full_o and empty_o are decoded from registered count. They are not affected by same-cycle push/pop.

Optional Feature:
- Macro: STORE_BUFFER_COALESCE_EN.
- Defined: a push whose word address matches the newest valid entry merges into that entry instead of allocating a new one.
  - Bytes with strobe=1 overwrite the entry's bytes; the entry's strobe becomes the OR of old and new strobes.
  - Count is unchanged.
  - Merging is inhibited when the newest entry is the head with mem_write_valid_o=1; in that case a new entry is allocated.
  - A merge never sets overflow_o, even when the buffer is full.
- Not defined: every accepted store allocates a new entry.

Test Plan:
- Reset, then a store of 0xDEADBEEF to 0x100 with strobe 0xF while ready=0 -> next cycle valid=1, address=0x100, data=0xDEADBEEF, strobe=0xF, empty_o=0; outputs hold stable for 5 cycles; ready=1 pops and empty_o=1 next cycle.
- With ready=0, push 4 stores (DEPTH=4), then a 5th -> full_o=1, 5th dropped, overflow_o=1; drain with ready=1 -> addresses pop in order 1-4 on consecutive cycles.
- Store 0x000000AA strobe 0x1 and 0x0000BB00 strobe 0x2 to 0x200, ready=0, mem_read_data_i=0x11223344, load from 0x200 -> core_read_data_o=0x1122BBAA.
- Two stores to 0x300 (0x01 then 0x02, both strobe 0x1) -> load 0x300 returns low byte 0x02 (newest wins).
- Full buffer, then push and ready=1 in the same cycle -> no overflow, count stays 4, the new entry appears at the tail.
- Assert reset_i mid-drain with 3 entries -> valid=0 immediately, empty_o=1, subsequent loads return mem_read_data_i unmodified.
